// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Load-use / redirect / memory-wait sequencing for the IF/ID stage
//            of the 5-stage RV32 pipeline. Optional counters: HAZ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW = 5
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    input  logic              imem_wait,
    input  logic              dmem_wait,
    output logic              pc_en,
    output logic [1:0]        instr_sel,
    output logic              load_use,
    output logic              id_ex_flush,
    output logic              pipe_hold,
    output logic [1:0]        ctrl_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  replay_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        REPLAY = 2'b01,
        HOLD   = 2'b10
    } state_t;

    state_t state_q, state_d, w_eff_state;
    logic   pend_replay_q, pend_replay_d;
    logic   w_lu_hit;
    logic   w_mwait;

    assign w_lu_hit = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));
    assign w_mwait  = imem_wait | dmem_wait;

    // A HOLD release cycle behaves like the state it resumes into.
    always_comb begin
        w_eff_state = state_q;
        if ((state_q == HOLD) && !w_mwait) begin
            w_eff_state = pend_replay_q ? REPLAY : RUN;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_replay_d = pend_replay_q;
        pc_en         = 1'b1;
        instr_sel     = 2'b00;
        load_use      = 1'b0;
        id_ex_flush   = 1'b0;
        pipe_hold     = 1'b0;
        if (!rst) begin
            case (w_eff_state)
                RUN: begin
                    state_d = RUN;
                    if (w_mwait) begin
                        pipe_hold = 1'b1;
                        pc_en     = 1'b0;
                        state_d   = HOLD;
                    end else if (ex_redirect) begin
                        instr_sel   = 2'b10;
                        id_ex_flush = 1'b1;
                    end else if (w_lu_hit) begin
                        load_use    = 1'b1;
                        pc_en       = 1'b0;
                        id_ex_flush = 1'b1;
                        state_d     = REPLAY;
                    end
                end
                REPLAY: begin
                    if (w_mwait) begin
                        pipe_hold     = 1'b1;
                        pc_en         = 1'b0;
                        pend_replay_d = 1'b1;
                        state_d       = HOLD;
                    end else if (ex_redirect) begin
                        instr_sel     = 2'b10;
                        id_ex_flush   = 1'b1;
                        pend_replay_d = 1'b0;
                        state_d       = RUN;
                    end else begin
                        instr_sel     = 2'b01;
                        pend_replay_d = 1'b0;
                        state_d       = RUN;
                    end
                end
                HOLD: begin
                    pipe_hold = 1'b1;
                    pc_en     = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pend_replay_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_replay_q <= pend_replay_d;
        end
    end

    assign ctrl_state = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
    logic [CNT_W-1:0] replay_cnt_q, replay_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        replay_cnt_d = replay_cnt_q;
        if ((pipe_hold || load_use) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((instr_sel == 2'b10) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if ((instr_sel == 2'b01) && (replay_cnt_q != '1)) begin
            replay_cnt_d = replay_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            replay_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            replay_cnt_q <= replay_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign replay_cnt = replay_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32 pipeline.
- Detects load-use hazards, taken branches/jumps and memory wait conditions, and drives the IF/ID stage controls:
  - instr_sel (00 pass, 01 replay held instruction, 10 inject NOP)
  - load_use (hold pc_ID)
  - PC enable
  - ID/EX bubble
  - global pipeline hold
- The IF/ID stage flushes the second wrong-path slot on its own, from a registered copy of instr_sel[1]. This block therefore issues a single-cycle flush request per redirect.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- id_rs1  input  REG_AW  ID-stage source 1 index
- id_rs2  input  REG_AW  ID-stage source 2 index
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- ex_rd  input  REG_AW  EX-stage destination index
- ex_mem_read  input  1  EX instruction is a load
- ex_redirect  input  1  EX has a taken branch or jump
- imem_wait  input  1  instruction memory not ready
- dmem_wait  input  1  data memory not ready
- pc_en  output  1  PC register update enable
- instr_sel  output  2  IF/ID instruction select
- load_use  output  1  hold pc_ID in IF/ID
- id_ex_flush  output  1  load NOP/bubble into ID/EX
- pipe_hold  output  1  freeze all pipeline registers
- ctrl_state  output  2  current FSM state (debug)

Behaviour:
- Reset values: state RUN, pend_replay=0, pc_en=1, instr_sel=00, load_use=0, id_ex_flush=0, pipe_hold=0, ctrl_state=00. Reset is honoured mid-sequence and aborts any replay or hold.
- Hazard term, combinational: lu_hit = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Wait term: mwait = imem_wait | dmem_wait.
- States: RUN=00, REPLAY=01, HOLD=10. All outputs are combinational from state and inputs, with zero-cycle latency.
- Per-cycle priority: mwait > ex_redirect > lu_hit > normal.
- RUN:
  - mwait: pipe_hold=1, pc_en=0, other outputs 0; next state HOLD.
  - else ex_redirect: instr_sel=10, id_ex_flush=1, pc_en=1; stay RUN. lu_hit is ignored because the ID instruction is wrong-path.
  - else lu_hit: load_use=1, pc_en=0, id_ex_flush=1, instr_sel=00; next state REPLAY.
  - else: all pass (pc_en=1, instr_sel=00).
- REPLAY (one cycle, re-presents the stalled instruction):
  - mwait: pipe_hold=1, pc_en=0, set pend_replay=1; next state HOLD.
  - else ex_redirect: instr_sel=10, id_ex_flush=1, pc_en=1; next state RUN. The replay is dropped.
  - else: instr_sel=01, pc_en=1; next state RUN. lu_hit cannot recur here because the load has moved past EX; if it is asserted anyway, it is ignored.
- HOLD:
  - While mwait: pipe_hold=1, pc_en=0, instr_sel=00, load_use=0, id_ex_flush=0.
  - On the first cycle with mwait=0: if pend_replay, output REPLAY behaviour this cycle, clear pend_replay, next state RUN; else next state RUN and the cycle is treated as RUN.
- ex_redirect is sampled only when pipe_hold=0. EX is frozen during a hold, so ex_redirect remains asserted and is acted on after release.
- x0 is never a hazard source.
- ctrl_state reflects the registered state, not the effective state in the release cycle.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cnt, flush_cnt, replay_cnt, each CNT_W wide and saturating at all-ones, cleared by rst.
  - stall_cnt increments every cycle pipe_hold=1 or load_use=1.
  - flush_cnt increments every cycle instr_sel=10.
  - replay_cnt increments every cycle instr_sel=01.
- Undefined: no counter ports and no counter logic; control behaviour is identical in both builds.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1.
  - Cycle 0: load_use=1, pc_en=0, id_ex_flush=1, state goes to REPLAY.
  - Cycle 1: instr_sel=01, pc_en=1.
  - Cycle 2: RUN.
- x0 filter: ex_mem_read=1, ex_rd=0, id_rs1=0, id_rs1_used=1 -> no stall; pc_en=1, instr_sel=00.
- Redirect plus load-use in the same cycle: ex_redirect=1 and lu_hit=1 -> instr_sel=10, id_ex_flush=1, load_use=0, state stays RUN.
- dmem_wait asserted 3 cycles during REPLAY:
  - 3 cycles of pipe_hold=1, pc_en=0.
  - Release cycle: instr_sel=01.
  - Next cycle: RUN.
- Async reset pulse mid-REPLAY (between clock edges) -> outputs return to reset values immediately; state is RUN at the next edge.
- With HAZ_PERF_CNT_EN: 2 load-use events, 1 redirect, 4 hold cycles -> stall_cnt=6, flush_cnt=1, replay_cnt=2. With CNT_W=2 forced, stall_cnt saturates at 3.
